// File: rtl/image_pkg.sv
// Shared types and constants for the image stream source.
// Pattern codes, colour-bar palette, pixel type and FSM states.
package image_pkg;

  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } tg_state_t;

  function automatic int cnt_width(input int total, input int min_w);
    int w;
    w = $clog2(total);
    return (w > min_w) ? w : min_w;
  endfunction

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    c = BAR_BLACK;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      3'd7: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running h/v counters, region decode and IDLE/RUN control.
// Region flags are combinational and lag-free relative to the counters.
module video_timing_gen
  import image_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HW       = 12,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hs,
  output logic          vs,
  output logic          valid,
  output logic          sof,
  output logic          run,
  output logic          load,
  output logic          h_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_HI = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_HI = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  tg_state_t state;
  tg_state_t state_nx;
  logic      v_last;
  logic      frame_last;

  assign h_last     = (h_cnt == H_END);
  assign v_last     = (v_cnt == V_END);
  assign frame_last = h_last && v_last;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (enable) state_nx = ST_RUN;
      ST_RUN:  if (frame_last && !enable) state_nx = ST_IDLE;
    endcase
  end

  // Counters stay at 0 on the IDLE->RUN edge so (0,0) is the first pixel.
  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  always_comb begin
    run   = (state == ST_RUN);
    valid = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs    = run && (h_cnt >= HS_LO) && (h_cnt <= HS_HI);
    vs    = run && (v_cnt >= VS_LO) && (v_cnt <= VS_HI);
    sof   = run && (h_cnt == '0) && (v_cnt == '0);
    load  = (state == ST_IDLE) ? enable : frame_last;
  end

endmodule

// File: rtl/image_stream_source.sv
// Test-pattern video source: timing generator, pattern mux, output regs.
// Pattern settings are frame-latched so a frame is never mixed.
module image_stream_source
  import image_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_rgb,
  output logic        vs_out,
  output logic        hs_out,
  output logic        valid_o,
  output logic [23:0] img_data_o,
  output logic        sof_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MIN_HW  = (CHECK_LOG2 + 1 > 8) ? CHECK_LOG2 + 1 : 8;
  localparam int HW      = cnt_width(H_TOTAL, MIN_HW);
  localparam int VW      = cnt_width(V_TOTAL, CHECK_LOG2 + 1);
  localparam logic [HW-1:0] BAR_END = HW'(H_ACTIVE / 8 - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          hs;
  logic          vs;
  logic          valid;
  logic          sof;
  logic          run;
  logic          load;
  logic          h_last;

  logic [1:0]    pat_q;
  logic [23:0]   solid_q;
  logic [HW-1:0] bar_pos;
  logic [2:0]    bar_idx;
  rgb_t          pix;

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .hs     (hs),
    .vs     (vs),
    .valid  (valid),
    .sof    (sof),
    .run    (run),
    .load   (load),
    .h_last (h_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if (load) begin
      pat_q   <= pattern_sel;
      solid_q <= solid_rgb;
    end
  end

  // Bar index follows h_cnt without a divider.
  always_ff @(posedge clk) begin
    if (reset || !run || h_last) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else if (bar_pos == BAR_END) begin
      bar_pos <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_pos <= bar_pos + HW'(1);
    end
  end

  always_comb begin
    pix = '0;
    unique case (pat_q)
      PAT_BARS:  pix = bar_color(bar_idx);
      PAT_RAMP:  pix = {3{h_cnt[7:0]}};
      PAT_CHECK: pix = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ?
                       24'hFFFFFF : 24'h000000;
      PAT_SOLID: pix = solid_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_out     <= 1'b0;
      hs_out     <= 1'b0;
      valid_o    <= 1'b0;
      sof_o      <= 1'b0;
      img_data_o <= '0;
    end else begin
      vs_out     <= vs;
      hs_out     <= hs;
      valid_o    <= valid;
      sof_o      <= sof;
      img_data_o <= valid ? pix : 24'h0;
    end
  end

endmodule

// File: tb/tb_image_stream_source.sv
// Directed bench for image_stream_source with a 24x8 raster.
// Each sample is {vs,hs,valid,sof,rgb} compared to hand-derived values.
module tb_image_stream_source;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        vs_out;
  logic        hs_out;
  logic        valid_o;
  logic [23:0] img_data_o;
  logic        sof_o;

  int checks;
  int errors;

  image_stream_source #(
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (3),
    .V_ACTIVE   (4),
    .V_FP       (1),
    .V_SYNC     (2),
    .V_BP       (1),
    .CHECK_LOG2 (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .vs_out      (vs_out),
    .hs_out      (hs_out),
    .valid_o     (valid_o),
    .img_data_o  (img_data_o),
    .sof_o       (sof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {4'h0, vs_out, hs_out, valid_o, sof_o, img_data_o};
  endfunction

  // Expected outputs for raster position p of a frame, p = v*24 + h.
  function automatic logic [31:0] exp_vec(input int pat,
                                          input logic [23:0] solid,
                                          input int p);
    logic [23:0] bars [8];
    int          h;
    int          v;
    logic        va;
    logic        hsx;
    logic        vsx;
    logic        sx;
    logic [7:0]  x8;
    logic [23:0] rgb;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    h   = p % 24;
    v   = p / 24;
    va  = (h < 16) && (v < 4);
    hsx = (h >= 18) && (h <= 20);
    vsx = (v >= 5) && (v <= 6);
    sx  = (p == 0);
    x8  = 8'(h);
    rgb = 24'h0;
    if (va) begin
      case (pat)
        0: rgb = bars[h / 2];
        1: rgb = {x8, x8, x8};
        2: rgb = ((h % 8) >= 4) ? 24'hFFFFFF : 24'h000000;
        default: rgb = solid;
      endcase
    end
    return {4'h0, vsx, hsx, va, sx, rgb};
  endfunction

  // Checks one frame from p=0; applies a settings change at chg_p and
  // optionally drops enable during line 1.
  task automatic check_frame(input int fr, input int pat,
                             input logic [23:0] solid,
                             input int chg_p, input logic [1:0] chg_sel,
                             input logic [23:0] chg_rgb,
                             input logic drop_en);
    int nv;
    int nh;
    int nvs;
    int ns;
    nv = 0; nh = 0; nvs = 0; ns = 0;
    for (int p = 0; p < 192; p++) begin
      chk($sformatf("f%0d_p%0d", fr, p), obs_vec(),
          exp_vec(pat, solid, p));
      nv  += int'(valid_o);
      nh  += int'(hs_out);
      nvs += int'(vs_out);
      ns  += int'(sof_o);
      if (p == chg_p) begin
        pattern_sel = chg_sel;
        solid_rgb   = chg_rgb;
      end
      if (drop_en && p == 30) enable = 1'b0;
      @(posedge clk);
      #1;
    end
    chk($sformatf("f%0d_valid_cnt", fr), 32'(nv), 32'd64);
    chk($sformatf("f%0d_hs_cnt", fr), 32'(nh), 32'd24);
    chk($sformatf("f%0d_vs_cnt", fr), 32'(nvs), 32'd48);
    chk($sformatf("f%0d_sof_cnt", fr), 32'(ns), 32'd1);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_rgb   = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", obs_vec(), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_out", obs_vec(), 32'h0);

    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("start_edge_k", obs_vec(), 32'h0);
    @(posedge clk);
    #1;
    chk("start_sof", 32'(sof_o), 32'd1);

    check_frame(1, 0, 24'h0, 100, 2'd1, 24'h0, 1'b0);
    check_frame(2, 1, 24'h0, 100, 2'd2, 24'h0, 1'b0);
    check_frame(3, 2, 24'h0, 100, 2'd0, 24'h0, 1'b0);
    check_frame(4, 0, 24'h0, 100, 2'd3, 24'h123456, 1'b0);
    check_frame(5, 3, 24'h123456, 500, 2'd3, 24'h123456, 1'b1);

    for (int i = 0; i < 30; i++) begin
      chk($sformatf("stopped_%0d", i), obs_vec(), 32'h0);
      @(posedge clk);
      #1;
    end

    enable = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_edge_k", obs_vec(), 32'h0);
    @(posedge clk);
    #1;
    chk("restart_p0", obs_vec(), exp_vec(3, 24'h123456, 0));
    repeat (5) @(posedge clk);
    #1;
    chk("restart_p5", obs_vec(), exp_vec(3, 24'h123456, 5));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_reset", obs_vec(), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_edge_k", obs_vec(), 32'h0);
    @(posedge clk);
    #1;
    check_frame(6, 3, 24'h123456, 500, 2'd3, 24'h123456, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_stream_source.md
# image_stream_source

Parameterised video stream source that generates the frame timing and pixel stream consumed by the image-processing chain, for example grayscale conversion and the relief effect. It produces `vs_out`, `hs_out`, `valid_o` and 24-bit RGB `img_data_o` from free-running horizontal and vertical counters, and fills active pixels with a selectable test pattern. It sits at the head of the pipeline for bring-up and regression, standing in for the camera or HDMI receive path.

## Interface
Parameters:
- `H_ACTIVE`, default 1280: active pixels per line; must be a multiple of 8.
- `H_FP`, default 110: horizontal front porch, in clocks.
- `H_SYNC`, default 40: horizontal sync width, in clocks.
- `H_BP`, default 220: horizontal back porch, in clocks.
- `V_ACTIVE`, default 720: active lines per frame.
- `V_FP`, default 5: vertical front porch, in lines.
- `V_SYNC`, default 5: vertical sync width, in lines.
- `V_BP`, default 20: vertical back porch, in lines.
- `CHECK_LOG2`, default 5: log2 of the checkerboard square size, in pixels.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: run request; sampled at frame boundaries only.
- `pattern_sel` in 2: 0 = colour bars, 1 = gray ramp, 2 = checkerboard, 3 = solid colour.
- `solid_rgb` in 24: colour used when `pattern_sel` is 3.
- `vs_out` out 1: vertical sync, active-high.
- `hs_out` out 1: horizontal sync, active-high.
- `valid_o` out 1: high for active pixels.
- `img_data_o` out 24: pixel as {R,G,B}.
- `sof_o` out 1: one-cycle pulse coincident with pixel (0,0).

## Operation
- Totals: `H_TOTAL` = H_ACTIVE+H_FP+H_SYNC+H_BP and `V_TOTAL` = V_ACTIVE+V_FP+V_SYNC+V_BP.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments on each `h_cnt` wrap and wraps to 0 after V_TOTAL-1.
- Horizontal regions, in order: active [0, H_ACTIVE-1], front porch, sync, back porch.
  - `hs` is high for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- Vertical regions follow the same order. `vs` is high for whole lines with `v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- `valid` = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- State machine:
  - IDLE: counters held at 0, all outputs 0. Goes to RUN when `enable`=1.
  - RUN: counters advance. At the last clock of a frame (`h_cnt`=H_TOTAL-1 and `v_cnt`=V_TOTAL-1):
    - if `enable`=0, go to IDLE;
    - otherwise stay in RUN.
  - A frame that has started always completes in full; deasserting `enable` mid-frame never truncates it.
- `pattern_sel` and `solid_rgb` are latched on entry to RUN and at every frame wrap. Mid-frame changes take effect from the next frame.
- Patterns, with x = `h_cnt` and y = `v_cnt`:
  - Bars: 8 bars of width H_ACTIVE/8, tracked with a bar counter and no divider. Colours, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - Ramp: {3{x[7:0]}}, wrapping every 256 pixels.
  - Checker: (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? FFFFFF : 000000.
  - Solid: the latched `solid_rgb`.
- `img_data_o` is 0 whenever `valid_o`=0.

## Timing
- All outputs are registered. Every output is 0 under reset and while in IDLE.
- Outputs lag the counters by exactly 1 clock. `vs_out`, `hs_out`, `valid_o`, `img_data_o` and `sof_o` are mutually aligned.
- Start-up:
  - `enable` is sampled high in IDLE at rising edge k, and the counters read (0,0) during cycle k..k+1.
  - `valid_o`=1 and `sof_o`=1 first appear after edge k+1.
- Steady state: frame period = H_TOTAL×V_TOTAL clocks; `valid_o` is high for H_ACTIVE consecutive clocks per active line.
- Reset asserted mid-frame: the next edge forces IDLE, zero counters and zero outputs. Restart follows the start-up rule.
- `enable` toggling within a frame has no effect until the frame boundary.

## Structure
- Shared package `image_pkg`:
  - pattern select constants PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_SOLID;
  - 24-bit colour-bar constants;
  - the RGB pixel typedef.
- Sub-module `video_timing_gen`: counters, region decode and the IDLE/RUN FSM. It outputs `h_cnt`, `v_cnt`, `hs`, `vs`, `valid`, `sof` unregistered.
- The top level adds the pattern mux and the output register stage.

## Test plan
Small parameters throughout: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, CHECK_LOG2=2. This gives H_TOTAL=24, V_TOTAL=8 and 192 clocks per frame.

1. Reset, then `enable`=1 from edge k, bars:
   - `sof_o` pulses after edge k+1;
   - each active line reads FFFFFF,FFFFFF, FFFF00,FFFF00, … ,000000,000000;
   - 16 valid pixels per line, 4 lines per frame.
2. Timing check:
   - `hs_out` high for 3 clocks, starting 2 clocks after the last valid pixel of each line;
   - `vs_out` high for 48 clocks (2 lines), starting after 1 blank line;
   - period is 192 clocks.
3. Ramp (`pattern_sel`=1): line pixels are 000000, 010101 … 0F0F0F. Checker (`pattern_sel`=2): row 0 reads 4×000000 then 4×FFFFFF alternating; rows 0..3 are identical.
4. Pattern change: switch `pattern_sel` 0→3 with `solid_rgb`=123456 mid-frame. The current frame stays bars; the next frame is all 123456.
5. Stop and reset:
   - drop `enable` during line 1; the frame completes and all outputs are 0 from the frame boundary onward;
   - separately, assert `reset` mid-line; all outputs are 0 after the next edge;
   - re-enable after reset; start-up latency is 2 edges again.
